// File: rtl/gearbox_fifo.sv
// Width-converting FIFO: IN_WIDTH writes, OUT_WIDTH first-word-fall-through reads,
// stored as UNIT-wide slots in a circular buffer of DEPTH slots (any DEPTH, not just powers of two).
module gearbox_fifo #(
  parameter int IN_WIDTH     = 64,
  parameter int OUT_WIDTH    = 32,
  parameter int DEPTH        = 16,
  parameter int AFULL_LEVEL  = DEPTH - 2,
  parameter int AEMPTY_LEVEL = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         write_en,
  input  logic [IN_WIDTH-1:0]          data_in,
  input  logic                         read_en,
  output logic [OUT_WIDTH-1:0]         data_out,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int UNIT  = (IN_WIDTH < OUT_WIDTH) ? IN_WIDTH : OUT_WIDTH;
  localparam int WIDE  = (IN_WIDTH < OUT_WIDTH) ? OUT_WIDTH : IN_WIDTH;
  localparam int WR    = IN_WIDTH / UNIT;
  localparam int RD    = OUT_WIDTH / UNIT;
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW    = PW + 1;

  localparam logic [LVL_W-1:0] WR_L    = LVL_W'(WR);
  localparam logic [LVL_W-1:0] RD_L    = LVL_W'(RD);
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] AF_L    = LVL_W'(AFULL_LEVEL);
  localparam logic [LVL_W-1:0] AE_L    = LVL_W'(AEMPTY_LEVEL);
  localparam logic [SW-1:0]    DEPTH_S = SW'(DEPTH);

  if (WIDE % UNIT != 0) begin : g_ratio_chk
    $fatal(1, "gearbox_fifo: wider port width must be a multiple of the narrower one");
  end
  if (DEPTH < WIDE / UNIT) begin : g_depth_chk
    $fatal(1, "gearbox_fifo: DEPTH must hold at least one wide word");
  end

  // base + off never reaches 2*DEPTH, so one conditional subtract wraps it.
  function automatic logic [PW-1:0] slot_idx(input logic [PW-1:0] base, input int unsigned off);
    logic [SW-1:0] sum;
    sum = {1'b0, base} + SW'(off);
    return (sum >= DEPTH_S) ? PW'(sum - DEPTH_S) : PW'(sum);
  endfunction

  logic [UNIT-1:0]  mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             wr_acc, rd_acc;

  assign full         = (DEPTH_L - level_q) < WR_L;
  assign empty        = level_q < RD_L;
  assign almost_full  = level_q >= AF_L;
  assign almost_empty = level_q <= AE_L;
  assign level        = level_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  always_comb begin
    wr_acc   = write_en && !full && !flush;
    rd_acc   = read_en && !empty && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = slot_idx(wr_ptr_q, WR);
      if (rd_acc) rd_ptr_d = slot_idx(rd_ptr_q, RD);
      level_d = level_q + (wr_acc ? WR_L : '0) - (rd_acc ? RD_L : '0);
      ovf_d   = ovf_q | (write_en & full);
      unf_d   = unf_q | (read_en & empty);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage is data only; it is never cleared, only overwritten.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int i = 0; i < WR; i++) begin
        mem_q[slot_idx(wr_ptr_q, i)] <= data_in[i*UNIT +: UNIT];
      end
    end
  end

  always_comb begin
    data_out = '0;
    if (!empty) begin
      for (int j = 0; j < RD; j++) begin
        data_out[j*UNIT +: UNIT] = mem_q[slot_idx(rd_ptr_q, j)];
      end
    end
  end

endmodule

// File: doc/gearbox_fifo.md
Name: gearbox_fifo

Overview:
- Parametrised successor to the single-width FIFO buffer, with independent write and read widths.
- Either width must be an integer multiple of the other.
- Stores data in UNIT-wide slots, where UNIT = min(IN_WIDTH, OUT_WIDTH).
- Adds occupancy reporting, programmable almost-full/almost-empty flags, synchronous flush and sticky overflow/underflow flags.
- Sits between producers and consumers of different bus widths, e.g. 64-bit packed input to 32-bit coefficient consumers, or the reverse.

Parameters:
IN_WIDTH, 64, write data width in bits.
OUT_WIDTH, 32, read data width in bits. max(IN_WIDTH,OUT_WIDTH) % min(IN_WIDTH,OUT_WIDTH) == 0 (checked at elaboration, fatal otherwise).
DEPTH, 16, capacity in UNIT slots. Must be >= max(IN_WIDTH,OUT_WIDTH)/UNIT. Need not be a power of two.
AFULL_LEVEL, DEPTH-2, almost_full asserts when level >= AFULL_LEVEL.
AEMPTY_LEVEL, 1, almost_empty asserts when level <= AEMPTY_LEVEL.

Ports:
clk  in  1  clock, all logic on rising edge.
rst  in  1  synchronous, active-high reset.
flush  in  1  synchronous clear of contents and error flags.
write_en  in  1  write request.
data_in  in  IN_WIDTH  write data; bits [UNIT-1:0] form the first slot.
read_en  in  1  read request.
data_out  out  OUT_WIDTH  head data, first-word-fall-through; bits [UNIT-1:0] are the oldest slot.
full  out  1  fewer than IN_WIDTH/UNIT free slots.
empty  out  1  fewer than OUT_WIDTH/UNIT stored slots.
almost_full  out  1  see AFULL_LEVEL.
almost_empty  out  1  see AEMPTY_LEVEL.
level  out  $clog2(DEPTH+1)  slots currently stored.
overflow  out  1  sticky: write_en while full.
underflow  out  1  sticky: read_en while empty.

Behaviour:
- Ratios: WR = IN_WIDTH/UNIT, RD = OUT_WIDTH/UNIT.
- Write/read slot pointers each wrap from DEPTH-1 to 0, modulo DEPTH. A WR- or RD-slot access may straddle the wrap point; slots are stored in order regardless.
- Write (write_en && !full): stores WR slots at wr_ptr..wr_ptr+WR-1. wr_ptr += WR mod DEPTH; level += WR.
- Read (read_en && !empty): pops RD slots. rd_ptr += RD mod DEPTH; level -= RD.
- data_out is combinational from storage at rd_ptr, valid whenever !empty. When empty it must be deterministic but its value is don't-care.
- Flag evaluation:
  - full, empty, almost_full and almost_empty are combinational from the registered level.
  - Read and write acceptance is decided on the pre-edge level.
  - Simultaneous accepted read and write: level_next = level + WR - RD.
  - A write into an empty FIFO is visible on data_out the cycle after the edge; there is no same-cycle bypass.
- Rejected operations:
  - Write while full: data is dropped, pointers unchanged, overflow set the next cycle.
  - Read while empty: no pointer change, underflow set the next cycle.
  - An accepted operation in the same cycle still proceeds.
- overflow/underflow hold until rst or flush.
- flush: pointers, level and error flags go to 0 on the next edge. Flush has priority over write_en/read_en in the same cycle; those requests are ignored and set no error flags.
- Reset (rst=1 at an edge) has priority over everything, including mid-operation:
  - pointers, level = 0;
  - empty = 1, full = 0 (given DEPTH >= WR);
  - almost_empty = 1, almost_full = 0 (given AFULL_LEVEL > 0);
  - overflow = underflow = 0.
  - Storage contents are not reset.
- Latency: write to data_out visibility is 1 cycle. A narrow-in/wide-out FIFO needs RD/WR writes before empty deasserts.
- Arithmetic: level is wide enough for DEPTH. The pointer wrap uses a compare-subtract, not a power-of-two mask.

Test Plan:
1. IN=64, OUT=32, DEPTH=8. Write 0x11112222_33334444 then read twice -> data_out 0x33334444 then 0x11112222; level 2 -> 1 -> 0; empty=1 after the second read.
2. IN=64, OUT=32, DEPTH=8. Four writes -> level=8, full=1. Fifth write with 0xDEAD -> dropped, overflow=1 next cycle, level stays 8. Reads return the first four words in order.
3. IN=16, OUT=64, DEPTH=8. Write 0x0001, 0x0002, 0x0003 -> empty stays 1. Write 0x0004 -> empty=0 next cycle, data_out=0x0004_0003_0002_0001.
4. IN=64, OUT=32, DEPTH=6 (non-power-of-two). Continuous interleaved traffic, write 1 per 2 cycles, read 1 per cycle when not empty, for 100 words -> every slot sequence matches a scoreboard across pointer wraps; no overflow or underflow.
5. Level 4 with write_en=1, read_en=1, flush=1 in the same cycle -> next cycle level=0, empty=1, overflow=0, underflow=0. Follow with read_en while empty -> underflow=1, held until the next flush.
6. Assert rst mid-stream with level=5 and overflow=1 -> next cycle level=0, empty=1, almost_empty=1, full=0, overflow=0. A subsequent write/read pair returns the new data correctly.
